adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

- Schedules periodic conversions on a shared single-port 12-bit ADC across up to `N_CH` proximity-sensor channels.
- Applies per-channel hysteresis thresholds to each result.
- Publishes a combined `can_move_fwd` go/no-go to the motion logic once per scan.
- Sits between the ADC interface block and the drive controller; owns all ADC start/channel-select traffic.

## Interface
- `N_CH`, 4: number of channels, 1..8.
- `CLK_HZ`, 25000000: clk frequency.
- `SAMPLE_HZ`, 1000: scan rate.
- `HIGH`, 12'd3000: set threshold; result strictly above → channel clear (1).
- `LOW`, 12'd1000: reset threshold; result strictly below → channel blocked (0). HIGH > LOW required.
- `TIMEOUT_CYC`, 1024: max cycles from `adc_start` to `adc_done`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset rst, asynchronous, active-high.
- `enable` in 1: permit new scans.
- `ch_mask` in N_CH: channels included in a scan.
- `adc_start` out 1: one-cycle conversion request.
- `adc_ch` out $clog2(N_CH) (min 1): channel for current conversion, stable from `adc_start` until done or timeout.
- `adc_done` in 1: one-cycle result strobe; `adc_data` valid in the same cycle.
- `adc_data` in 12: conversion result.
- `ch_clear` out N_CH: per-channel hysteresis state.
- `can_move_fwd` out 1: AND of `ch_clear` over the mask latched for the scan.
- `scan_done` out 1: one-cycle pulse at end of each scan.
- `timeout_err` out 1: sticky error flag, set on any conversion timeout.
- `overrun_err` out 1: sticky error flag, set when a tick arrives with a scan in progress.
- `err_clr` in 1: clears `timeout_err` and `overrun_err`.

## Operation
- Tick divider:
  - Free-running counter, period `CLK_HZ/SAMPLE_HZ` cycles.
  - `tick` is high for one cycle at wrap; the counter runs regardless of `enable`.
- FSM states: IDLE, START, CONVERT, NEXT, DONE.
  - IDLE: on `tick` with `enable`=1 and `ch_mask`≠0, latch the mask, select the lowest set channel, go to START.
    - On `tick` with mask==0 and `enable`=1: go directly to DONE; `can_move_fwd` becomes 0.
  - START: `adc_start`=1 for exactly one cycle; clear the timeout counter; go to CONVERT.
  - CONVERT:
    - On `adc_done`: update that channel's hysteresis state and go to NEXT.
    - If the timeout counter reaches `TIMEOUT_CYC-1` without `adc_done`: force that channel's `ch_clear` to 0, set `timeout_err`, go to NEXT.
  - NEXT: select the next higher set bit of the latched mask and go to START; if none remains, go to DONE.
  - DONE: register `can_move_fwd` = AND of `ch_clear` over the latched mask; pulse `scan_done`; go to IDLE.
- Hysteresis per channel:
  - `adc_data < LOW` → 0.
  - `adc_data > HIGH` → 1.
  - Otherwise hold; values equal to LOW or HIGH hold.
  - Unmasked channels hold their state.
- `adc_done` outside CONVERT is ignored.
- `tick` outside IDLE sets `overrun_err`; the current scan continues and no extra scan is queued.
- Deasserting `enable` mid-scan does not abort the scan; it completes, then the FSM stays in IDLE.
- Changing `ch_mask` mid-scan has no effect until the next scan.
- `err_clr` together with a new error event in the same cycle: the set wins.

## Timing
- Reset values:
  - `adc_start`, `scan_done`, `can_move_fwd`, `timeout_err`, `overrun_err`: 0.
  - `ch_clear`: all 0; `adc_ch`: 0.
  - FSM in IDLE; divider at 0.
- `tick` at cycle T → `adc_start` at T+1.
- `adc_done` at cycle D → `ch_clear` updated at D+1 (NEXT); next `adc_start` at D+2.
- Last channel done at D → DONE at D+2, with `scan_done` and the new `can_move_fwd` visible from D+2.
- Timeout: `adc_start` at S with no `adc_done` → CONVERT exits at S+TIMEOUT_CYC, flag forced 0 from S+TIMEOUT_CYC+1.
- Async `rst` mid-conversion returns every output to its reset value immediately; a late `adc_done` after reset is ignored.

## Structure
- Package `adc_pkg`: `ADC_W`=12, FSM state enum `scan_state_t`, result typedef `adc_sample_t`.
- Sub-module `adc_hyst_cell`, one per channel:
  - Inputs: `clk`, `rst`, `upd`, `force_clr`, `data`.
  - Output: `clear`.
  - Parameters: `HIGH`, `LOW`.
- The top level holds the divider, FSM, timeout counter, mask walker and error flags.

## Test plan
- Reset mid-CONVERT on ch2 → all outputs 0 the same cycle; a subsequent `adc_done` causes no flag change.
- Mask 4'b1111, ADC returns 3500 on all channels, done 5 cycles after each start → `adc_ch` sequence 0,1,2,3; `can_move_fwd`=1 with `scan_done`.
- Hysteresis on ch0 (mask 4'b0001), successive scans with 3500, 2000, 3000, 999, 1000, 3001 → `ch_clear[0]` = 1,1,1,0,0,1.
- Mask 4'b0101, ch2 never answers → `timeout_err`=1 exactly TIMEOUT_CYC cycles after ch2 start; `ch_clear[2]`=0; `can_move_fwd`=0.
- `adc_done` held off past the next tick → `overrun_err`=1, exactly one scan completes, no double start; `err_clr` then clears `overrun_err`.
- Mask 0 with `enable`=1 → no `adc_start`, `scan_done` pulses each tick, `can_move_fwd`=0. With `enable`=0 → no `scan_done`.

Source files
------------

// File: rtl/adc_scan_sequencer_pkg.sv
// Shared types for the ADC scan sequencer: sample width, scan FSM states and
// the hysteresis update rule used by every channel cell.
package adc_pkg;

  localparam int ADC_W = 12;

  typedef logic [ADC_W-1:0] adc_sample_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_CONVERT = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } scan_state_t;

  // Strict compares: a result sitting exactly on a threshold keeps the old state
  function automatic logic hyst_next(input logic cur, input adc_sample_t data,
                                     input adc_sample_t high, input adc_sample_t low);
    logic nxt;
    if (data < low) begin
      nxt = 1'b0;
    end else if (data > high) begin
      nxt = 1'b1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Handshake between the scan sequencer (master) and the ADC interface block
// (slave): start/channel request out, done/data strobe back.
interface adc_scan_sequencer_if #(
  parameter int N_CH = 4
);
  import adc_pkg::*;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            adc_start;
  logic [CH_W-1:0] adc_ch;
  logic            adc_done;
  adc_sample_t     adc_data;

  modport master (
    output adc_start,
    output adc_ch,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    input  adc_ch,
    output adc_done,
    output adc_data
  );

endinterface

// File: rtl/adc_scan_sequencer_hyst.sv
// One proximity channel's clear/blocked state with set/reset thresholds; a
// conversion timeout forces the channel to blocked.
module adc_hyst_cell
  import adc_pkg::*;
#(
  parameter adc_sample_t HIGH = 12'd3000,
  parameter adc_sample_t LOW  = 12'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic        force_clr,
  input  adc_sample_t data,
  output logic        clear
);

  logic r_clear;

  // Channel state register; a forced clear outranks a same-cycle update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clear <= 1'b0;
    end else if (force_clr) begin
      r_clear <= 1'b0;
    end else if (upd) begin
      r_clear <= hyst_next(r_clear, data, HIGH, LOW);
    end else begin
      r_clear <= r_clear;
    end
  end

  assign clear = r_clear;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic ADC scan sequencer: divides clk into scan ticks, walks the latched
// channel mask one conversion at a time and publishes a go/no-go per scan.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          CLK_HZ      = 25000000,
  parameter int          SAMPLE_HZ   = 1000,
  parameter adc_sample_t HIGH        = 12'd3000,
  parameter adc_sample_t LOW         = 12'd1000,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_mask,
  adc_scan_sequencer_if.master adc_bus,
  output logic [N_CH-1:0]      ch_clear,
  output logic                 can_move_fwd,
  output logic                 scan_done,
  output logic                 timeout_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  scan_state_t     r_state;
  logic [DIV_W-1:0] r_div;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [N_CH-1:0] r_mask;
  logic [CH_W-1:0] r_ch;
  logic            r_adc_start;
  logic            r_scan_done;
  logic            r_can_move_fwd;
  logic            r_timeout_err;
  logic            r_overrun_err;

  logic            w_tick;
  logic            w_conv_done;
  logic            w_timeout;
  logic [CH_W-1:0] w_first_idx;
  logic            w_first_ok;
  logic [CH_W-1:0] w_next_idx;
  logic            w_next_ok;
  logic [N_CH-1:0] w_upd;
  logic [N_CH-1:0] w_force;

  // Free-running scan-rate divider, independent of enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick      = (r_div == DIV_LAST);
  assign w_conv_done = (r_state == S_CONVERT) && adc_bus.adc_done;
  assign w_timeout   = (r_state == S_CONVERT) && !adc_bus.adc_done && (r_tmo_cnt == TMO_LAST);

  // Mask walker: lowest set bit of the live mask, next set bit above r_ch in the latched one
  always_comb begin
    w_first_idx = '0;
    w_first_ok  = 1'b0;
    w_next_idx  = '0;
    w_next_ok   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_first_idx = ch_mask[i] ? CH_W'(i) : w_first_idx;
      w_first_ok  = w_first_ok | ch_mask[i];
      w_next_idx  = (r_mask[i] && (i > int'(r_ch))) ? CH_W'(i) : w_next_idx;
      w_next_ok   = w_next_ok | (r_mask[i] && (i > int'(r_ch)));
    end
  end

  // Per-channel update/force strobes for the channel currently converting
  always_comb begin
    w_upd   = '0;
    w_force = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_upd[i]   = w_conv_done && (r_ch == CH_W'(i));
      w_force[i] = w_timeout && (r_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    adc_hyst_cell #(
      .HIGH (HIGH),
      .LOW  (LOW)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .upd       (w_upd[g]),
      .force_clr (w_force[g]),
      .data      (adc_bus.adc_data),
      .clear     (ch_clear[g])
    );
  end

  // Scan FSM with registered start/select/done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tmo_cnt      <= '0;
      r_mask         <= '0;
      r_ch           <= '0;
      r_adc_start    <= 1'b0;
      r_scan_done    <= 1'b0;
      r_can_move_fwd <= 1'b0;
    end else begin
      r_adc_start <= 1'b0;
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick && enable) begin
            r_mask <= ch_mask;
            if (w_first_ok) begin
              r_ch        <= w_first_idx;
              r_adc_start <= 1'b1;
              r_state     <= S_START;
            end else begin
              // An empty mask is never a permission to move
              r_can_move_fwd <= 1'b0;
              r_scan_done    <= 1'b1;
              r_state        <= S_DONE;
            end
          end
        end
        S_START: begin
          r_tmo_cnt <= '0;
          r_state   <= S_CONVERT;
        end
        S_CONVERT: begin
          if (adc_bus.adc_done || (r_tmo_cnt == TMO_LAST)) begin
            r_state <= S_NEXT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        S_NEXT: begin
          if (w_next_ok) begin
            r_ch        <= w_next_idx;
            r_adc_start <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_can_move_fwd <= &(ch_clear | ~r_mask);
            r_scan_done    <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun_err <= 1'b1;
      end else if (err_clr) begin
        r_overrun_err <= 1'b0;
      end else begin
        r_overrun_err <= r_overrun_err;
      end
    end
  end

  assign adc_bus.adc_start = r_adc_start;
  assign adc_bus.adc_ch    = r_ch;
  assign scan_done         = r_scan_done;
  assign can_move_fwd      = r_can_move_fwd;
  assign timeout_err       = r_timeout_err;
  assign overrun_err       = r_overrun_err;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: a cycle-timed scan model checks
// every output each cycle, directed scenarios add hand-computed expectations.
module tb_adc_scan_sequencer;

  localparam int P      = 40;
  localparam int TMO    = 64;
  localparam int HIGH_T = 3000;
  localparam int LOW_T  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic       err_clr = 1'b0;
  logic [3:0] ch_clear;
  logic       can_move_fwd, scan_done, timeout_err, overrun_err;

  int n_checks = 0;
  int n_errors = 0;

  adc_scan_sequencer_if #(.N_CH(4)) bus ();

  adc_scan_sequencer #(
    .N_CH(4), .CLK_HZ(400), .SAMPLE_HZ(10),
    .HIGH(12'd3000), .LOW(12'd1000), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .adc_bus(bus),
    .ch_clear(ch_clear), .can_move_fwd(can_move_fwd), .scan_done(scan_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (timing rules of a scan) ----------------
  int       m_cyc, m_div, m_start_c, m_finish_c, m_cur;
  bit       m_busy, m_conv;
  int       m_q[$];
  logic [3:0] m_lmask, m_clr;
  logic     m_cmf_pend;
  logic     e_start, e_done, e_cmf, e_terr, e_oerr;
  logic [1:0] e_ch;

  function automatic logic hyst(input logic s, input int d);
    if (d < LOW_T) return 1'b0;
    if (d > HIGH_T) return 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_div = 0; m_start_c = -10; m_finish_c = -10; m_cur = 0;
    m_busy = 0; m_conv = 0; m_q.delete();
    m_lmask = 4'b0000; m_clr = 4'b0000; m_cmf_pend = 1'b0;
    e_start = 1'b0; e_done = 1'b0; e_cmf = 1'b0; e_terr = 1'b0; e_oerr = 1'b0;
    e_ch = 2'd0;
  endtask

  task automatic model_step();
    bit tick, ev_ovr, ev_tmo, fin;
    tick   = (m_div == P - 1);
    ev_ovr = tick && m_busy;
    ev_tmo = 0;
    if (!m_busy) begin
      if (tick && enable) begin
        m_busy = 1; m_lmask = ch_mask; m_q.delete();
        for (int i = 0; i < 4; i++) if (ch_mask[i]) m_q.push_back(i);
        if (m_q.size() == 0) begin
          m_finish_c = m_cyc + 1; m_cmf_pend = 1'b0;
        end else begin
          m_cur = m_q.pop_front(); m_start_c = m_cyc + 1; m_conv = 1;
        end
      end
    end else if (m_conv && m_cyc > m_start_c) begin
      fin = 0;
      if (bus.adc_done) begin
        m_clr[m_cur] = hyst(m_clr[m_cur], int'(bus.adc_data)); fin = 1;
      end else if (m_cyc == m_start_c + TMO) begin
        m_clr[m_cur] = 1'b0; ev_tmo = 1; fin = 1;
      end
      if (fin) begin
        m_conv = 0;
        if (m_q.size() != 0) begin
          m_cur = m_q.pop_front(); m_start_c = m_cyc + 2; m_conv = 1;
        end else begin
          m_finish_c = m_cyc + 2; m_cmf_pend = &(m_clr | ~m_lmask);
        end
      end
    end
    if (m_busy && m_cyc == m_finish_c) m_busy = 0;
    e_start = m_conv && (m_start_c == m_cyc + 1);
    if (e_start) e_ch = m_cur[1:0];
    e_done = (m_finish_c == m_cyc + 1);
    if (e_done) e_cmf = m_cmf_pend;
    e_terr = ev_tmo ? 1'b1 : (err_clr ? 1'b0 : e_terr);
    e_oerr = ev_ovr ? 1'b1 : (err_clr ? 1'b0 : e_oerr);
    m_div = (m_div + 1) % P;
    m_cyc++;
  endtask

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (rst) model_reset();
    check("model_adc_start", bus.adc_start, e_start);
    check("model_adc_ch", bus.adc_ch, e_ch);
    check("model_scan_done", scan_done, e_done);
    check("model_can_move_fwd", can_move_fwd, e_cmf);
    check("model_ch_clear", ch_clear, m_clr);
    check("model_timeout_err", timeout_err, e_terr);
    check("model_overrun_err", overrun_err, e_oerr);
    if (!rst) model_step();
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic step_cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      step_cyc();
      if (bus.adc_start) begin ok = 1; break; end
    end
    if (!ok) check("wait_adc_start_bound", 0, 1);
  endtask

  task automatic wait_scan_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      step_cyc();
      if (scan_done) begin ok = 1; break; end
    end
    if (!ok) check("wait_scan_done_bound", 0, 1);
  endtask

  task automatic respond(input int dly, input int val, output int ch);
    bit ok;
    ch = -1;
    wait_start(ok);
    if (ok) begin
      ch = int'(bus.adc_ch);
      repeat (dly) step_cyc();
      bus.adc_done = 1'b1; bus.adc_data = 12'(val);
      step_cyc();
      bus.adc_done = 1'b0;
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; step_cyc(); err_clr = 1'b0;
  endtask

  task automatic full_scan_test();
    int ch; bit ok;
    enable = 1'b1; ch_mask = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      respond(5, 3500, ch);
      check($sformatf("seq_adc_ch_%0d", k), ch, k);
      if (k == 0) ch_mask = 4'b0001;
    end
    enable = 1'b0;
    wait_scan_done(ok);
    check("full_scan_can_move_fwd", can_move_fwd, 1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int ch, k, n_done, n_start;
    bit ok;
    int hvals[6] = '{3500, 2000, 3000, 999, 1000, 3001};
    logic hexp[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.adc_done = 1'b0; bus.adc_data = 12'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_adc_ch", bus.adc_ch, 0);
    check("reset_ch_clear", ch_clear, 0);

    full_scan_test();

    // Reset while converting ch2
    enable = 1'b1; ch_mask = 4'b0100;
    wait_start(ok);
    check("rst_test_ch", bus.adc_ch, 2);
    enable = 1'b0;
    repeat (3) step_cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_adc_start", bus.adc_start, 0);
    check("rst_adc_ch", bus.adc_ch, 0);
    check("rst_ch_clear", ch_clear, 0);
    check("rst_can_move_fwd", can_move_fwd, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_errs", {timeout_err, overrun_err}, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.adc_done = 1'b1; bus.adc_data = 12'd3500;
    step_cyc();
    bus.adc_done = 1'b0;
    step_cyc();
    check("late_done_ch_clear", ch_clear, 0);
    check("late_done_errs", {timeout_err, overrun_err}, 0);

    full_scan_test();

    // Hysteresis sequence on ch0
    enable = 1'b1; ch_mask = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      respond(5, hvals[i], ch);
      wait_scan_done(ok);
      check($sformatf("hyst_ch0_step%0d", i), ch_clear[0], hexp[i]);
    end
    enable = 1'b0;

    // Timeout on ch2
    enable = 1'b1; ch_mask = 4'b0101;
    respond(5, 3500, ch);
    wait_start(ok);
    check("tmo_ch", bus.adc_ch, 2);
    enable = 1'b0;
    repeat (TMO) step_cyc();
    check("tmo_err_before", timeout_err, 0);
    check("tmo_clr2_before", ch_clear[2], 1);
    step_cyc();
    check("tmo_err_after", timeout_err, 1);
    check("tmo_clr2_after", ch_clear[2], 0);
    wait_scan_done(ok);
    check("tmo_can_move_fwd", can_move_fwd, 0);
    check("tmo_clr0", ch_clear[0], 1);
    pulse_err_clr();
    check("tmo_errs_cleared", {timeout_err, overrun_err}, 0);

    // Overrun: ADC answers after the next tick
    enable = 1'b1; ch_mask = 4'b0001;
    wait_start(ok);
    n_done = 0; n_start = 0;
    for (k = 1; k < 200; k++) begin
      step_cyc();
      if (k == 45) begin bus.adc_done = 1'b1; bus.adc_data = 12'd3500; end
      if (k == 46) bus.adc_done = 1'b0;
      if (bus.adc_start) break;
      if (scan_done) n_done++;
    end
    check("ovr_start_gap", k, 2 * P);
    check("ovr_scans_done", n_done, 1);
    check("ovr_flag", overrun_err, 1);
    enable = 1'b0;
    repeat (5) step_cyc();
    bus.adc_done = 1'b1; bus.adc_data = 12'd3500;
    step_cyc();
    bus.adc_done = 1'b0;
    wait_scan_done(ok);
    pulse_err_clr();
    check("ovr_cleared", overrun_err, 0);

    // Empty mask
    ch_mask = 4'b0000; enable = 1'b1;
    n_done = 0; n_start = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step_cyc();
      if (scan_done) begin
        n_done++;
        check("empty_can_move_fwd", can_move_fwd, 0);
      end
      if (bus.adc_start) n_start++;
    end
    check("empty_scan_done_count", n_done, 3);
    check("empty_no_start", n_start, 0);
    enable = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step_cyc();
      if (scan_done) n_done++;
    end
    check("disabled_scan_done_count", n_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
